// File: rtl/bram_pkg.sv
// Shared BRAM line definitions: line geometry, word/line types, reader FSM states.
package bram_pkg;

    localparam int unsigned WORDS_PER_LINE = 4;
    localparam int unsigned WORD_BYTES     = 4;
    localparam int unsigned LINE_BYTES     = 16;

    typedef logic [31:0]  word_t;
    typedef logic [127:0] line_t;
    typedef logic [1:0]   word_idx_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_WAIT    = 3'd2,
        ST_PRESENT = 3'd3,
        ST_DONE    = 3'd4
    } rd_state_t;

    function automatic word_t bswap32(input word_t w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/bram_rd_pipe.sv
// Tracks in-flight BRAM reads: an RD_LAT-deep shift register of issue tags that
// yields a capture strobe and the word index exactly when the read data is valid.
module bram_rd_pipe
    import bram_pkg::*;
#(
    parameter int unsigned RD_LAT = 1
) (
    input  logic      S_AXI_ACLK,
    input  logic      S_AXI_ARESET,
    input  logic      issue,
    input  word_idx_t issue_idx,
    output logic      cap_valid,
    output word_idx_t cap_idx
);

    logic [RD_LAT-1:0] vld_sr;
    word_idx_t         tag_sr [RD_LAT];

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            vld_sr <= '0;
            for (int unsigned i = 0; i < RD_LAT; i++) begin
                tag_sr[i] <= '0;
            end
        end else begin
            vld_sr[0] <= issue;
            tag_sr[0] <= issue_idx;
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                vld_sr[i] <= vld_sr[i-1];
                tag_sr[i] <= tag_sr[i-1];
            end
        end
    end

    assign cap_valid = vld_sr[RD_LAT-1];
    assign cap_idx   = tag_sr[RD_LAT-1];

endmodule

// File: rtl/bram_line_reader.sv
// Reads 128-bit lines back from BRAM port B as four 32-bit words and streams them out.
// Optional BRAM_LINE_READER_BSWAP_EN: byte-reverse each word on capture.
module bram_line_reader
    import bram_pkg::*;
#(
    parameter int unsigned ADDR_W   = 15,
    parameter int unsigned RD_LAT   = 1,
    parameter int unsigned NLINES_W = 8
) (
    input  logic                S_AXI_ACLK,
    input  logic                S_AXI_ARESET,
    input  logic                i_trigger,
    input  logic [ADDR_W-1:0]   i_base_addr,
    input  logic [NLINES_W-1:0] i_num_lines,
    output logic                o_busy,
    output logic                o_end,
    output logic                o_bram_en,
    output logic [3:0]          o_bram_we,
    output logic [ADDR_W-1:0]   o_bram_addr,
    input  logic [31:0]         i_bram_rddata,
    output logic [127:0]        o_line_data,
    output logic                o_line_valid,
    input  logic                i_line_ready,
    output logic                o_line_last
);

    rd_state_t           state;
    logic                trig_q;
    logic [ADDR_W-1:0]   line_base;
    logic [NLINES_W-1:0] num_lines;
    logic [NLINES_W-1:0] line_cnt;
    word_idx_t           fetch_k;
    logic                cap_valid;
    word_idx_t           cap_idx;
    word_t               cap_word;

    assign o_bram_we = '0;

`ifdef BRAM_LINE_READER_BSWAP_EN
    assign cap_word = bswap32(i_bram_rddata);
`else
    assign cap_word = i_bram_rddata;
`endif

    bram_rd_pipe #(.RD_LAT(RD_LAT)) u_rd_pipe (
        .S_AXI_ACLK   (S_AXI_ACLK),
        .S_AXI_ARESET (S_AXI_ARESET),
        .issue        (o_bram_en),
        .issue_idx    (fetch_k),
        .cap_valid    (cap_valid),
        .cap_idx      (cap_idx)
    );

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            state        <= ST_IDLE;
            trig_q       <= 1'b0;
            line_base    <= '0;
            num_lines    <= '0;
            line_cnt     <= '0;
            fetch_k      <= '0;
            o_busy       <= 1'b0;
            o_end        <= 1'b0;
            o_bram_en    <= 1'b0;
            o_bram_addr  <= '0;
            o_line_data  <= '0;
            o_line_valid <= 1'b0;
            o_line_last  <= 1'b0;
        end else begin
            trig_q <= i_trigger;
            // Captures land in the output buffer directly; it is only exposed while valid.
            if (cap_valid) begin
                o_line_data[cap_idx*32 +: 32] <= cap_word;
            end
            case (state)
                ST_IDLE: begin
                    o_end <= 1'b0;
                    if (i_trigger && !trig_q) begin
                        line_base <= i_base_addr;
                        num_lines <= i_num_lines;
                        line_cnt  <= '0;
                        o_busy    <= 1'b1;
                        if (i_num_lines == '0) begin
                            state <= ST_DONE;
                        end else begin
                            state       <= ST_FETCH;
                            o_bram_en   <= 1'b1;
                            o_bram_addr <= i_base_addr;
                            fetch_k     <= '0;
                        end
                    end
                end
                ST_FETCH: begin
                    if (fetch_k == word_idx_t'(WORDS_PER_LINE - 1)) begin
                        o_bram_en <= 1'b0;
                        state     <= ST_WAIT;
                    end else begin
                        fetch_k     <= fetch_k + 2'd1;
                        o_bram_addr <= o_bram_addr + ADDR_W'(WORD_BYTES);
                    end
                end
                ST_WAIT: begin
                    if (cap_valid && cap_idx == word_idx_t'(WORDS_PER_LINE - 1)) begin
                        o_line_valid <= 1'b1;
                        o_line_last  <= (line_cnt == num_lines - NLINES_W'(1));
                        state        <= ST_PRESENT;
                    end
                end
                ST_PRESENT: begin
                    if (i_line_ready) begin
                        o_line_valid <= 1'b0;
                        o_line_last  <= 1'b0;
                        line_cnt     <= line_cnt + NLINES_W'(1);
                        if (o_line_last) begin
                            state <= ST_DONE;
                        end else begin
                            line_base   <= line_base + ADDR_W'(LINE_BYTES);
                            o_bram_addr <= line_base + ADDR_W'(LINE_BYTES);
                            o_bram_en   <= 1'b1;
                            fetch_k     <= '0;
                            state       <= ST_FETCH;
                        end
                    end
                end
                ST_DONE: begin
                    o_end  <= 1'b1;
                    o_busy <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
